// File: rtl/proc_multi_stage.sv
// Match-action packet sequencer: parser once, then matcher/executor per enabled stage.
// Optional watchdog on every wait state is built only when PROC_TIMEOUT_EN is defined.
module proc_multi_stage #(
    parameter int NUM_STAGES = 4,
    parameter int ADDR_W     = 32,
    parameter int STAGE_W    = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
`ifdef PROC_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 1024
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    output logic                  ready_o,
    output logic                  busy_o,
    output logic                  err_o,
    output logic [NUM_STAGES-1:0] hit_vec_o,
    output logic [31:0]           pkt_cnt_o,
    output logic                  ps_start_o,
    input  logic                  ps_ready_i,
    output logic                  mt_start_o,
    input  logic                  mt_ready_i,
    output logic [STAGE_W-1:0]    mt_stage_o,
    input  logic                  mt_is_match_i,
    output logic                  ex_start_o,
    input  logic                  ex_ready_i,
    output logic [ADDR_W-1:0]     ex_op_start_cnt_o,
    input  logic                  cfg_we_i,
    input  logic [STAGE_W-1:0]    cfg_stage_i,
    input  logic                  cfg_en_i,
    input  logic [ADDR_W-1:0]     cfg_hit_addr_i,
    input  logic [ADDR_W-1:0]     cfg_miss_addr_i,
    output logic                  cfg_ack_o
);

    typedef enum logic [2:0] {FREE, PARSE, MATCH, EXEC, DONE} state_t;

    state_t                state, next_state;
    logic                  ready, next_ready;
    logic                  err, next_err;
    logic                  ps_start, next_ps_start;
    logic                  mt_start, next_mt_start;
    logic                  ex_start, next_ex_start;
    logic                  cfg_ack, next_cfg_ack;
    logic [NUM_STAGES-1:0] hit_vec, next_hit_vec;
    logic [31:0]           pkt_cnt, next_pkt_cnt;
    logic [STAGE_W-1:0]    mt_stage, next_mt_stage;
    logic [ADDR_W-1:0]     ex_op, next_ex_op;

    logic [NUM_STAGES-1:0] en_mask;
    logic [ADDR_W-1:0]     hit_addr  [NUM_STAGES];
    logic [ADDR_W-1:0]     miss_addr [NUM_STAGES];
    logic                  cfg_write;

    logic                  first_found, upper_found;
    logic [STAGE_W-1:0]    first_stage, upper_stage;

`ifdef PROC_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TMO_W-1:0] tmo_cnt, next_tmo_cnt;
`endif

    // Descending scan so the lowest matching index is the one left standing.
    always_comb begin
        first_found = 1'b0;
        first_stage = '0;
        upper_found = 1'b0;
        upper_stage = '0;
        for (int i = NUM_STAGES - 1; i >= 0; i--) begin
            if (en_mask[i]) begin
                first_found = 1'b1;
                first_stage = STAGE_W'(i);
            end
            if (en_mask[i] && (i > int'(mt_stage))) begin
                upper_found = 1'b1;
                upper_stage = STAGE_W'(i);
            end
        end
    end

    assign cfg_write = (state == FREE) && cfg_we_i && (int'(cfg_stage_i) < NUM_STAGES);

    always_comb begin
        next_state    = state;
        next_ready    = ready;
        next_err      = err;
        next_ps_start = ps_start;
        next_mt_start = mt_start;
        next_ex_start = ex_start;
        next_cfg_ack  = 1'b0;
        next_hit_vec  = hit_vec;
        next_pkt_cnt  = pkt_cnt;
        next_mt_stage = mt_stage;
        next_ex_op    = ex_op;

        case (state)
            FREE: begin
                if (cfg_we_i) begin
                    next_cfg_ack = 1'b1;
                end else if (start_i) begin
                    next_ready    = 1'b0;
                    next_err      = 1'b0;
                    next_hit_vec  = '0;
                    next_ps_start = 1'b1;
                    next_state    = PARSE;
                end
            end
            PARSE: begin
                if (ps_start && ps_ready_i) begin
                    next_ps_start = 1'b0;
                    if (!first_found) begin
                        next_ready   = 1'b1;
                        next_pkt_cnt = pkt_cnt + 32'd1;
                        next_state   = DONE;
                    end else begin
                        next_mt_stage = first_stage;
                        next_mt_start = 1'b1;
                        next_state    = MATCH;
                    end
                end
            end
            MATCH: begin
                if (mt_start && mt_ready_i) begin
                    next_mt_start          = 1'b0;
                    next_hit_vec[mt_stage] = mt_is_match_i;
                    next_ex_op    = mt_is_match_i ? hit_addr[mt_stage] : miss_addr[mt_stage];
                    next_ex_start = 1'b1;
                    next_state    = EXEC;
                end
            end
            EXEC: begin
                if (ex_start && ex_ready_i) begin
                    next_ex_start = 1'b0;
                    if (upper_found) begin
                        next_mt_stage = upper_stage;
                        next_mt_start = 1'b1;
                        next_state    = MATCH;
                    end else begin
                        next_ready   = 1'b1;
                        next_pkt_cnt = pkt_cnt + 32'd1;
                        next_state   = DONE;
                    end
                end
            end
            DONE: begin
                if (!start_i) begin
                    next_state = FREE;
                end
            end
            default: next_state = FREE;
        endcase

`ifdef PROC_TIMEOUT_EN
        // Staying put in a wait state means the expected ready has not arrived.
        next_tmo_cnt = (next_state != state) ? '0 : tmo_cnt + TMO_W'(1);
        if ((state == PARSE || state == MATCH || state == EXEC) && (next_state == state)
            && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1))) begin
            next_ps_start = 1'b0;
            next_mt_start = 1'b0;
            next_ex_start = 1'b0;
            next_err      = 1'b1;
            next_ready    = 1'b1;
            next_pkt_cnt  = pkt_cnt + 32'd1;
            next_state    = DONE;
            next_tmo_cnt  = '0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FREE;
            ready    <= 1'b0;
            err      <= 1'b0;
            ps_start <= 1'b0;
            mt_start <= 1'b0;
            ex_start <= 1'b0;
            cfg_ack  <= 1'b0;
            hit_vec  <= '0;
            pkt_cnt  <= '0;
            mt_stage <= '0;
            ex_op    <= '0;
        end else begin
            state    <= next_state;
            ready    <= next_ready;
            err      <= next_err;
            ps_start <= next_ps_start;
            mt_start <= next_mt_start;
            ex_start <= next_ex_start;
            cfg_ack  <= next_cfg_ack;
            hit_vec  <= next_hit_vec;
            pkt_cnt  <= next_pkt_cnt;
            mt_stage <= next_mt_stage;
            ex_op    <= next_ex_op;
        end
    end

`ifdef PROC_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= next_tmo_cnt;
        end
    end
`endif

    // Stage table; out-of-range writes still ack but never land here.
    always_ff @(posedge clk) begin
        if (rst) begin
            en_mask <= NUM_STAGES'(1);
            for (int i = 0; i < NUM_STAGES; i++) begin
                hit_addr[i]  <= '0;
                miss_addr[i] <= '0;
            end
        end else if (cfg_write) begin
            en_mask[cfg_stage_i]   <= cfg_en_i;
            hit_addr[cfg_stage_i]  <= cfg_hit_addr_i;
            miss_addr[cfg_stage_i] <= cfg_miss_addr_i;
        end
    end

    assign ready_o           = ready;
    assign busy_o            = (state != FREE) && (state != DONE);
    assign err_o             = err;
    assign hit_vec_o         = hit_vec;
    assign pkt_cnt_o         = pkt_cnt;
    assign ps_start_o        = ps_start;
    assign mt_start_o        = mt_start;
    assign mt_stage_o        = mt_stage;
    assign ex_start_o        = ex_start;
    assign ex_op_start_cnt_o = ex_op;
    assign cfg_ack_o         = cfg_ack;

endmodule
